// File: rtl/vote_xfer_ctrl.sv
// Vote collection and two-phase handshake transfer controller.
// Optional handshake timeout is enabled by defining VOTE_XFER_TMO_EN.
module vote_xfer_ctrl #(
    parameter int           W     = 4,
    parameter logic [W-1:0] MATCH = W'(6),
    parameter int           CW    = 8,
    parameter int           TMO   = 255
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          test_i,
    input  logic          start_i,
    input  logic          key_i,
    input  logic [W-2:0]  buttons_i,
    input  logic          rts_i,
    input  logic          rtr_i,
    input  logic [W-1:0]  v_in_i,
    output logic          cts_o,
    output logic          ctr_o,
    output logic [W-1:0]  v_out_o,
    output logic [CW-1:0] xfer_cnt_o,
    output logic          err_o
);

    localparam logic [3:0] S_INIT  = 4'd0;
    localparam logic [3:0] S_SELF  = 4'd1;
    localparam logic [3:0] S_WAIT  = 4'd2;
    localparam logic [3:0] S_COLL  = 4'd3;
    localparam logic [3:0] S_PAR   = 4'd4;
    localparam logic [3:0] S_TX    = 4'd5;
    localparam logic [3:0] S_RXREQ = 4'd6;
    localparam logic [3:0] S_RX    = 4'd7;
    localparam logic [3:0] S_ACK   = 4'd8;
    localparam logic [3:0] S_FIN   = 4'd9;

    logic [3:0]    state_q, state_d;
    logic [W-1:0]  vote_q, vote_d;
    logic [W-2:0]  last_b_q, last_b_d;
    logic          cts_q, cts_d;
    logic          ctr_q, ctr_d;
    logic [W-1:0]  v_out_q, v_out_d;
    logic [CW-1:0] xfer_cnt_q, xfer_cnt_d;

`ifdef VOTE_XFER_TMO_EN
    localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);

    logic [TW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
    logic          in_wait;

    assign in_wait = (state_q == S_TX) || (state_q == S_RXREQ) || (state_q == S_RX) ||
                     (state_q == S_ACK) || (state_q == S_FIN);
`endif

    always_comb begin
        state_d    = state_q;
        vote_d     = vote_q;
        last_b_d   = last_b_q;
        cts_d      = cts_q;
        ctr_d      = ctr_q;
        v_out_d    = v_out_q;
        xfer_cnt_d = xfer_cnt_q;
        case (state_q)
            S_INIT: begin
                vote_d  = '0;
                cts_d   = 1'b0;
                ctr_d   = 1'b0;
                state_d = test_i ? S_WAIT : S_SELF;
            end
            S_SELF: begin
                // Exit decision uses the vote loaded on the previous cycle.
                vote_d = v_in_i;
                if (&vote_q) state_d = S_TX;
            end
            S_WAIT: begin
                cts_d = rtr_i;
                if (start_i) begin
                    vote_d  = '0;
                    state_d = S_COLL;
                end
            end
            S_COLL: begin
                if (!start_i) begin
                    state_d = S_PAR;
                end else if (key_i) begin
                    // Rising-edge toggle: only a newly pressed button flips its bit.
                    vote_d[W-2:0] = vote_q[W-2:0] ^ (buttons_i & ~last_b_q);
                    last_b_d      = buttons_i;
                end else begin
                    vote_d = '0;
                end
            end
            S_PAR: begin
                vote_d[W-1] = ^vote_q[W-2:0];
                state_d     = S_TX;
            end
            S_TX: begin
                if (rtr_i) begin
                    v_out_d    = vote_q;
                    cts_d      = 1'b1;
                    xfer_cnt_d = xfer_cnt_q + CW'(1);
                    state_d    = (vote_q == MATCH) ? S_FIN : S_RXREQ;
                end
            end
            S_RXREQ: begin
                if (!rts_i) begin
                    ctr_d   = 1'b1;
                    state_d = S_RX;
                end
            end
            S_RX: begin
                if (rts_i) begin
                    vote_d  = v_in_i;
                    ctr_d   = 1'b0;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!rtr_i) begin
                    cts_d   = 1'b0;
                    state_d = S_TX;
                end
            end
            S_FIN: begin
                if (!rtr_i) begin
                    cts_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_INIT;
        endcase

`ifdef VOTE_XFER_TMO_EN
        err_d = err_q;
        // Timeout overrides whatever handshake step the case above selected.
        if (in_wait && (wait_q == TW'(TMO - 1))) begin
            err_d   = 1'b1;
            cts_d   = 1'b0;
            ctr_d   = 1'b0;
            state_d = S_INIT;
        end
        if (state_d != state_q)
            wait_d = '0;
        else if (in_wait)
            wait_d = wait_q + TW'(1);
        else
            wait_d = wait_q;
`endif
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_INIT;
            vote_q     <= '0;
            last_b_q   <= '0;
            cts_q      <= 1'b0;
            ctr_q      <= 1'b0;
            v_out_q    <= '0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            vote_q     <= vote_d;
            last_b_q   <= last_b_d;
            cts_q      <= cts_d;
            ctr_q      <= ctr_d;
            v_out_q    <= v_out_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

`ifdef VOTE_XFER_TMO_EN
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TMO != 0);
    assign err_o      = 1'b0;
`endif

    assign cts_o      = cts_q;
    assign ctr_o      = ctr_q;
    assign v_out_o    = v_out_q;
    assign xfer_cnt_o = xfer_cnt_q;

endmodule

// File: tb/tb_vote_xfer_ctrl.sv
// Directed self-checking bench for vote_xfer_ctrl (W=4, TMO=4).
module tb_vote_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       test;
    logic       start;
    logic       key;
    logic [2:0] buttons;
    logic       rts;
    logic       rtr;
    logic [3:0] v_in;
    logic       cts;
    logic       ctr;
    logic [3:0] v_out;
    logic [7:0] xfer_cnt;
    logic       err;

    int total = 0;
    int bad   = 0;

    vote_xfer_ctrl #(.W(4), .MATCH(4'b0110), .CW(8), .TMO(4)) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .test_i     (test),
        .start_i    (start),
        .key_i      (key),
        .buttons_i  (buttons),
        .rts_i      (rts),
        .rtr_i      (rtr),
        .v_in_i     (v_in),
        .cts_o      (cts),
        .ctr_o      (ctr),
        .v_out_o    (v_out),
        .xfer_cnt_o (xfer_cnt),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; test = 1'b1; start = 1'b0; key = 1'b0; buttons = 3'b000;
        rts = 1'b1; rtr = 1'b0; v_in = 4'b0000;
        #3;
        check("rst_cts", 32'(cts), 32'd0);
        check("rst_ctr", 32'(ctr), 32'd0);
        check("rst_vout", 32'(v_out), 32'd0);
        check("rst_cnt", 32'(xfer_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("init_to_wait", 32'(dut.state_q), 32'd2);

        // Session 1: buttons 1 and 2 rise -> 0110 == MATCH -> S_FIN
        start = 1'b1; key = 1'b1; buttons = 3'b000;
        tick();
        check("wait_to_coll", 32'(dut.state_q), 32'd3);
        buttons = 3'b110;
        tick();
        check("toggle_110", 32'(dut.vote_q), 32'h6);
        tick();
        check("held_no_toggle", 32'(dut.vote_q), 32'h6);
        start = 1'b0;
        tick();
        check("coll_to_par", 32'(dut.state_q), 32'd4);
        tick();
        check("par_to_tx", 32'(dut.state_q), 32'd5);
        check("par_even", 32'(dut.vote_q), 32'h6);
        rtr = 1'b1;
        tick();
        check("s1_vout", 32'(v_out), 32'h6);
        check("s1_cts", 32'(cts), 32'd1);
        check("s1_cnt", 32'(xfer_cnt), 32'd1);
        check("s1_fin", 32'(dut.state_q), 32'd9);
        rtr = 1'b0;
        tick();
        check("fin_cts", 32'(cts), 32'd0);
        check("fin_to_wait", 32'(dut.state_q), 32'd2);

        // Session 2: bit 0 only -> parity -> 1001, then receive 0110
        start = 1'b1; key = 1'b1; buttons = 3'b000;
        tick();
        buttons = 3'b001;
        tick();
        check("toggle_001", 32'(dut.vote_q), 32'h1);
        start = 1'b0;
        tick();
        tick();
        check("par_odd", 32'(dut.vote_q), 32'h9);
        rtr = 1'b1;
        tick();
        check("s2_vout", 32'(v_out), 32'h9);
        check("s2_cnt", 32'(xfer_cnt), 32'd2);
        check("s2_rxreq", 32'(dut.state_q), 32'd6);
        tick();
        check("rxreq_hold", 32'(ctr), 32'd0);
        rts = 1'b0;
        tick();
        check("rx_ctr1", 32'(ctr), 32'd1);
        check("rx_state", 32'(dut.state_q), 32'd7);
        rts = 1'b1; v_in = 4'b0110;
        tick();
        check("rx_ctr0", 32'(ctr), 32'd0);
        check("rx_vote", 32'(dut.vote_q), 32'h6);
        check("ack_state", 32'(dut.state_q), 32'd8);
        rtr = 1'b0;
        tick();
        check("ack_cts0", 32'(cts), 32'd0);
        check("ack_to_tx", 32'(dut.state_q), 32'd5);
        rtr = 1'b1;
        tick();
        check("s2b_vout", 32'(v_out), 32'h6);
        check("s2b_cnt", 32'(xfer_cnt), 32'd3);
        check("s2b_fin", 32'(dut.state_q), 32'd9);
        rtr = 1'b0;
        tick();

        // Session 3: key=0 clears collected vote, last_b holds
        start = 1'b1; key = 1'b1; buttons = 3'b000;
        tick();
        tick();
        buttons = 3'b011;
        tick();
        check("toggle_011", 32'(dut.vote_q), 32'h3);
        key = 1'b0;
        tick();
        check("key0_clear", 32'(dut.vote_q), 32'h0);
        check("key0_lastb", 32'(dut.last_b_q), 32'h3);
        start = 1'b0;
        tick();
        tick();
        rtr = 1'b1;
        tick();
        check("s3_vout", 32'(v_out), 32'h0);
        check("s3_cnt", 32'(xfer_cnt), 32'd4);
        rts = 1'b0;
        tick();
        check("s3_ctr1", 32'(ctr), 32'd1);

        // Asynchronous reset mid-handshake
        #2 rst = 1'b1;
        #1;
        check("arst_ctr", 32'(ctr), 32'd0);
        check("arst_cts", 32'(cts), 32'd0);
        check("arst_vout", 32'(v_out), 32'd0);
        check("arst_cnt", 32'(xfer_cnt), 32'd0);
        check("arst_state", 32'(dut.state_q), 32'd0);

        // Self-load mode
        test = 1'b0; v_in = 4'b1111; rtr = 1'b0; rts = 1'b1; start = 1'b0; key = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("self_enter", 32'(dut.state_q), 32'd1);
        tick();
        check("self_stay", 32'(dut.state_q), 32'd1);
        tick();
        check("self_exit", 32'(dut.state_q), 32'd5);
        rtr = 1'b1;
        tick();
        check("self_vout", 32'(v_out), 32'hF);
        check("self_cnt", 32'(xfer_cnt), 32'd1);

        // Handshake timeout (or unbounded wait when the feature is off)
        rst = 1'b1;
        rtr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("tmo_in_tx", 32'(dut.state_q), 32'd5);
        tick();
        tick();
        tick();
        check("tmo_pre_err", 32'(err), 32'd0);
        check("tmo_pre_state", 32'(dut.state_q), 32'd5);
        tick();
`ifdef VOTE_XFER_TMO_EN
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_state", 32'(dut.state_q), 32'd0);
        test = 1'b1;
        tick();
        start = 1'b1; key = 1'b1; buttons = 3'b000;
        tick();
        buttons = 3'b110;
        tick();
        start = 1'b0;
        tick();
        tick();
        rtr = 1'b1;
        tick();
        check("tmo_good_vout", 32'(v_out), 32'h6);
        check("tmo_good_cnt", 32'(xfer_cnt), 32'd1);
        rtr = 1'b0;
        tick();
        check("tmo_sticky", 32'(err), 32'd1);
        check("tmo_back_wait", 32'(dut.state_q), 32'd2);
`else
        check("notmo_err", 32'(err), 32'd0);
        check("notmo_state", 32'(dut.state_q), 32'd5);
        tick();
        tick();
        check("notmo_hold", 32'(dut.state_q), 32'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vote_xfer_ctrl.md
VOTE_XFER_CTRL -- requirements
Module: vote_xfer_ctrl

Interface
REQ-001 Parameter W, default 4: vote word width, legal range 2..16.
REQ-002 Parameter MATCH, W bits, default 'b0110: vote value that ends a transfer session.
REQ-003 Parameter CW, default 8: width of the transfer counter.
REQ-004 Parameter TMO, default 255: handshake timeout in cycles (used only with VOTE_XFER_TMO_EN).
REQ-005 clock  in  1  only clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 test  in  1  0 in S_INIT selects self-load mode.
REQ-008 start  in  1  starts and ends vote collection.
REQ-009 key  in  1  enables vote entry; 0 clears the vote.
REQ-010 buttons  in  W-1  one toggle button per vote bit [W-2:0].
REQ-011 rts, rtr  in  1 each  partner request-to-send and ready-to-receive.
REQ-012 v_in  in  W  vote word from the partner.
REQ-013 cts, ctr  out  1 each  clear-to-send and clear-to-receive, registered.
REQ-014 v_out  out  W  last transmitted vote, registered.
REQ-015 xfer_cnt  out  CW  count of completed transmits.
REQ-016 err  out  1  sticky handshake-timeout flag.

Function
REQ-017 Internal registers SHALL be: vote[W-1:0], last_b[W-2:0] and a 4-bit state.
REQ-018 S_INIT SHALL clear vote, cts and ctr, then go to S_SELF if test=0, else to S_WAIT.
REQ-019 S_SELF SHALL load vote<=v_in every cycle and go to S_TX when the pre-load vote is all ones.
REQ-020 S_WAIT SHALL drive cts<=rtr; start=1 SHALL clear vote and go to S_COLL.
REQ-021 S_COLL with start=0 SHALL go to S_PAR.
REQ-022 S_COLL with start=1, key=1: bit i SHALL toggle when buttons[i]=1 and last_b[i]=0; last_b<=buttons.
REQ-023 S_COLL with start=1, key=0 SHALL clear vote; last_b SHALL hold.
REQ-024 S_PAR SHALL set vote[W-1] <= XOR of vote[W-2:0] and go to S_TX (one cycle).
REQ-025 S_TX with rtr=1: v_out<=vote, cts<=1, xfer_cnt increments (wraps at 2^CW); next is S_FIN if vote==MATCH, else S_RXREQ; with rtr=0 it holds.
REQ-026 S_RXREQ with rts=0: ctr<=1, go to S_RX.
REQ-027 S_RX with rts=1: vote<=v_in, ctr<=0, go to S_ACK.
REQ-028 S_ACK with rtr=0: cts<=0, go to S_TX.
REQ-029 S_FIN with rtr=0: cts<=0, go to S_WAIT.
REQ-030 Undefined state encodings SHALL go to S_INIT on the next clock.
REQ-031 Start-to-S_TX latency SHALL be: start fall, one cycle in S_PAR, then S_TX; v_out is valid the cycle after the S_TX acceptance edge.

Reset
REQ-032 Reset=1 SHALL immediately force state=S_INIT, vote=0, last_b=0, cts=0, ctr=0, v_out=0, xfer_cnt=0, err=0, independent of clock, including mid-handshake.
REQ-033 After reset release, the first rising edge SHALL evaluate S_INIT.

Configuration
REQ-034 With VOTE_XFER_TMO_EN defined, a wait counter SHALL clear on every state change and increment each cycle spent in S_TX, S_RXREQ, S_RX, S_ACK or S_FIN.
REQ-035 With VOTE_XFER_TMO_EN defined, the counter reaching TMO SHALL set err<=1 (sticky until reset), cts<=0, ctr<=0, state<=S_INIT; the timeout has priority over a handshake transition in the same cycle.
REQ-036 Without VOTE_XFER_TMO_EN, waits SHALL be unbounded, err SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-037 W=4; test=1, start 1 for 3 cycles with key=1, buttons rising on bits 1 and 2, then start=0, rtr=1 -> v_out=4'b0110, cts=1, xfer_cnt=1, then S_FIN; rtr=0 -> cts=0, back in S_WAIT.
REQ-038 Vote with bit 0 only -> parity bit set, v_out=4'b1001; rts 1->0 -> ctr=1; rts=1 with v_in=4'b0110 -> ctr=0; rtr 0->1 -> v_out=4'b0110.
REQ-039 test=0, v_in=4'b1111 held -> S_SELF exits after 2 cycles, first transmit v_out=4'b1111.
REQ-040 key=0 during collection after toggles -> vote=0, transmit gives v_out=4'b0000.
REQ-041 Assert reset while ctr=1 in S_RX -> ctr, cts, v_out, xfer_cnt are 0 before the next clock edge.
REQ-042 With VOTE_XFER_TMO_EN and TMO=4, hold rtr=0 in S_TX -> err=1 and state S_INIT 4 cycles later; err stays 1 through a later good transfer.
